// File: rtl/sram_flash_if.sv
// Initiator-side bus shared by the SRAM and the flash.
// The "master" modport is the initiator and "slave" is the responder.
interface sram_flash_if;
  logic [20:0] sram_flash_addr_;    // word address
  logic [15:0] sram_flash_data_i;   // write data, initiator -> responder
  logic [15:0] sram_flash_data_o;   // read data, responder -> initiator
  logic        sram_flash_data_oe;  // responder drives the data bus
  logic        sram_flash_oe_n_;    // active-low output enable
  logic        sram_flash_we_n_;    // active-low write enable
  logic [3:0]  sram_bw_;            // active-low byte enables, only [1:0] used
  logic        sram_cen_;           // active-low SRAM chip enable
  logic        flash_ce2_;          // active-high flash select when SRAM is off

  modport master (
    output sram_flash_addr_,
    output sram_flash_data_i,
    output sram_flash_oe_n_,
    output sram_flash_we_n_,
    output sram_bw_,
    output sram_cen_,
    output flash_ce2_,
    input  sram_flash_data_o,
    input  sram_flash_data_oe
  );

  modport slave (
    input  sram_flash_addr_,
    input  sram_flash_data_i,
    input  sram_flash_oe_n_,
    input  sram_flash_we_n_,
    input  sram_bw_,
    input  sram_cen_,
    input  flash_ce2_,
    output sram_flash_data_o,
    output sram_flash_data_oe
  );
endinterface

// File: rtl/sram_flash_responder.sv
// SRAM + read-only flash responder model.
// One command is sampled on every rising edge. The SRAM can be written byte by byte.
// The flash returns a fixed pattern built from the index.
// Reads pass through a request register, an array-read stage and an output stage.
// The data therefore appears two edges after the read is sampled, at one word per cycle.
module sram_flash_responder #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  sram_flash_if.slave bus,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic        err
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_SRAM_RD,
    CMD_SRAM_WR,
    CMD_FL_RD,
    CMD_CONTENTION,
    CMD_FL_WR
  } cmd_e;

  cmd_e            cmd;
  logic [AW-1:0]   idx;
  logic            wr_lo;
  logic            wr_hi;

  // Read request captured at the sampling edge.
  logic            req_valid;
  logic            req_flash;
  logic [AW-1:0]   req_idx;

  // Word fetched from the array on the following edge.
  logic            s1_valid;
  logic [15:0]     s1_data;

  // Output register. Its valid qualifies data_oe.
  logic            s2_valid;
  logic [15:0]     data_q;

  logic [15:0]     sram_word;
  logic [15:0]     rd_word;
  logic [15:0]     mem [DEPTH];

  // Upper address bits alias and byte enables [3:2] have no function.
  logic            unused_bits;
  assign unused_bits = ^{bus.sram_bw_[3:2], bus.sram_flash_addr_[20:AW]};

  assign idx = bus.sram_flash_addr_[AW-1:0];

  // Flash contents: {idx, ~idx} over an 8-bit view of the index.
  function automatic logic [15:0] flash_word(input logic [AW-1:0] i);
    logic [7:0] i8;
    i8 = 8'(i);
    return {i8, ~i8};
  endfunction

  // Classify the sampled bus state into one command.
  always_comb begin
    // NOTE: assign a default before any branch, so that every path leaves cmd defined and no latch is inferred.
    cmd = CMD_IDLE;
    if (!bus.sram_cen_) begin
      if (bus.sram_flash_we_n_ && !bus.sram_flash_oe_n_)
        cmd = CMD_SRAM_RD;
      else if (!bus.sram_flash_we_n_ && bus.sram_flash_oe_n_)
        cmd = CMD_SRAM_WR;
      else if (!bus.sram_flash_we_n_ && !bus.sram_flash_oe_n_)
        cmd = CMD_CONTENTION;
    end else if (bus.flash_ce2_) begin
      if (!bus.sram_flash_we_n_)
        cmd = CMD_FL_WR;
      else if (!bus.sram_flash_oe_n_)
        cmd = CMD_FL_RD;
    end
  end

  // Per-byte write strobes for a committed SRAM write.
  always_comb begin
    wr_lo = 1'b0;
    wr_hi = 1'b0;
    if (!rst && cmd == CMD_SRAM_WR) begin
      wr_lo = ~bus.sram_bw_[0];
      wr_hi = ~bus.sram_bw_[1];
    end
  end

  // Array read for the pending request.
  // A write landing on the same index at this edge is forwarded byte by byte (write-first).
  always_comb begin
    sram_word = mem[req_idx];
    if (idx == req_idx) begin
      if (wr_lo) sram_word[7:0]  = bus.sram_flash_data_i[7:0];
      if (wr_hi) sram_word[15:8] = bus.sram_flash_data_i[15:8];
    end
    rd_word = req_flash ? flash_word(req_idx) : sram_word;
  end

  // SRAM storage. It survives reset.
  // NOTE: the memory array has no reset; its contents must persist across rst, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_lo) mem[idx][7:0]  <= bus.sram_flash_data_i[7:0];
    if (wr_hi) mem[idx][15:8] <= bus.sram_flash_data_i[15:8];
  end

  // Read pipeline: request -> array word -> output register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment, so every stage samples the previous stage's old value.
    if (rst) begin
      req_valid <= 1'b0;
      req_flash <= 1'b0;
      req_idx   <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= 16'h0000;
      s2_valid  <= 1'b0;
      data_q    <= 16'h0000;
    end else begin
      req_valid <= (cmd == CMD_SRAM_RD) || (cmd == CMD_FL_RD);
      req_flash <= (cmd == CMD_FL_RD);
      req_idx   <= idx;
      s1_valid  <= req_valid;
      if (req_valid) s1_data <= rd_word;
      s2_valid  <= s1_valid;
      // Hold the last word through bubbles.
      if (s1_valid) data_q <= s1_data;
    end
  end

  // Transaction counters and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= 16'h0000;
      rd_cnt <= 16'h0000;
      err    <= 1'b0;
    end else begin
      if (cmd == CMD_SRAM_WR) wr_cnt <= wr_cnt + 16'h0001;
      if (cmd == CMD_SRAM_RD || cmd == CMD_FL_RD) rd_cnt <= rd_cnt + 16'h0001;
      if (cmd == CMD_CONTENTION || cmd == CMD_FL_WR) err <= 1'b1;
    end
  end

  assign bus.sram_flash_data_o  = data_q;
  // The output enable follows oe_n combinationally.
  assign bus.sram_flash_data_oe = s2_valid & ~bus.sram_flash_oe_n_;

endmodule
